// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, frame geometry and
// small helpers for cycle budgets and parity.
package ps2_host_tx_pkg;

  localparam int PS2_FRAME_BITS   = 11;
  localparam int PS2_PAYLOAD_BITS = 9;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_INHIBIT    = 4'd1,
    ST_REQ        = 4'd2,
    ST_WAIT_START = 4'd3,
    ST_SHIFT      = 4'd4,
    ST_WAIT_ACK   = 4'd5,
    ST_WAIT_IDLE  = 4'd6,
    ST_DONE       = 4'd7,
    ST_ERROR      = 4'd8
  } ps2_tx_state_e;

  function automatic int us_to_cycles(input longint clk_hz, input longint us);
    return int'((clk_hz * us) / 64'sd1000000);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // PS/2 uses odd parity over the eight data bits.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_host_tx_sync_edge.sv
// Two-flop synchroniser with falling-edge detect for one PS/2 pin; the idle
// bus level is high so every stage resets to 1.
module ps2_host_tx_sync_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pin,
  output logic o_level,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_pin;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_fall  = r_prev & ~r_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, bit shifting on device
// clock falling edges, ACK check and timeout supervision.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int INHIBIT_US  = 100,
  parameter int START_TO_US = 15000,
  parameter int FRAME_TO_US = 2000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int INHIBIT_CYC = us_to_cycles(longint'(CLK_FREQ_HZ), longint'(INHIBIT_US));
  localparam int START_CYC   = us_to_cycles(longint'(CLK_FREQ_HZ), longint'(START_TO_US));
  localparam int FRAME_CYC   = us_to_cycles(longint'(CLK_FREQ_HZ), longint'(FRAME_TO_US));
  localparam int TMR_W       = $clog2(max3(INHIBIT_CYC, START_CYC, FRAME_CYC));
  localparam int CNT_W       = $clog2(PS2_FRAME_BITS);

  localparam logic [TMR_W-1:0] INHIBIT_LAST = TMR_W'(INHIBIT_CYC - 1);
  localparam logic [TMR_W-1:0] START_LAST   = TMR_W'(START_CYC - 1);
  localparam logic [TMR_W-1:0] FRAME_LAST   = TMR_W'(FRAME_CYC - 1);
  localparam logic [CNT_W-1:0] PAYLOAD_CNT  = CNT_W'(PS2_PAYLOAD_BITS);

  ps2_tx_state_e               r_state;
  ps2_tx_state_e               w_next;
  logic [TMR_W-1:0]            r_tmr;
  logic [CNT_W-1:0]            r_bitcnt;
  logic [CNT_W-1:0]            w_bitcnt_nxt;
  logic [PS2_PAYLOAD_BITS-1:0] r_shift;
  logic [PS2_PAYLOAD_BITS-1:0] w_shift_nxt;
  logic r_busy, r_done, r_error, r_clk_oe, r_data_oe;
  logic w_busy_nxt, w_done_nxt, w_error_nxt, w_clk_oe_nxt, w_data_oe_nxt, w_drive_nxt;
  logic w_clk_lvl, w_clk_fall, w_data_lvl, w_data_fall_unused;
  logic w_inhibit_exp, w_start_exp, w_frame_exp;
  logic w_in_frame, w_next_in_frame, w_release;

  ps2_host_tx_sync_edge u_clk_sync (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_pin   (ps2_clk_in),
    .o_level (w_clk_lvl),
    .o_fall  (w_clk_fall)
  );

  ps2_host_tx_sync_edge u_data_sync (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_pin   (ps2_data_in),
    .o_level (w_data_lvl),
    .o_fall  (w_data_fall_unused)
  );

  assign w_inhibit_exp   = (r_tmr == INHIBIT_LAST);
  assign w_start_exp     = (r_tmr == START_LAST);
  assign w_frame_exp     = (r_tmr == FRAME_LAST);
  assign w_in_frame      = (r_state == ST_SHIFT) || (r_state == ST_WAIT_ACK) || (r_state == ST_WAIT_IDLE);
  assign w_next_in_frame = (w_next == ST_SHIFT) || (w_next == ST_WAIT_ACK) || (w_next == ST_WAIT_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Restarts on every state change, except that it keeps running from the
  // first device edge to the end of the frame so one budget covers it all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmr <= {TMR_W{1'b0}};
    end else if ((r_state == ST_IDLE) || ((w_next != r_state) && !(w_in_frame && w_next_in_frame))) begin
      r_tmr <= {TMR_W{1'b0}};
    end else begin
      r_tmr <= r_tmr + TMR_W'(1);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (tx_start) w_next = ST_INHIBIT;
        else          w_next = ST_IDLE;
      end
      ST_INHIBIT: begin
        if (w_inhibit_exp) w_next = ST_REQ;
        else               w_next = ST_INHIBIT;
      end
      ST_REQ: w_next = ST_WAIT_START;
      ST_WAIT_START: begin
        if (w_clk_fall)       w_next = ST_SHIFT;
        else if (w_start_exp) w_next = ST_ERROR;
        else                  w_next = ST_WAIT_START;
      end
      ST_SHIFT: begin
        if (w_clk_fall && (r_bitcnt == PAYLOAD_CNT)) w_next = ST_WAIT_ACK;
        else if (w_frame_exp)                       w_next = ST_ERROR;
        else                                        w_next = ST_SHIFT;
      end
      ST_WAIT_ACK: begin
        if (w_clk_fall)       w_next = w_data_lvl ? ST_ERROR : ST_WAIT_IDLE;
        else if (w_frame_exp) w_next = ST_ERROR;
        else                  w_next = ST_WAIT_ACK;
      end
      ST_WAIT_IDLE: begin
        if (w_clk_lvl && w_data_lvl) w_next = ST_DONE;
        else if (w_frame_exp)        w_next = ST_ERROR;
        else                         w_next = ST_WAIT_IDLE;
      end
      ST_DONE:  w_next = ST_IDLE;
      ST_ERROR: w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Next values for the registered outputs and the bit datapath.
  always_comb begin
    w_shift_nxt  = r_shift;
    w_bitcnt_nxt = r_bitcnt;
    w_drive_nxt  = r_data_oe;
    case (r_state)
      ST_IDLE: begin
        if (tx_start) begin
          w_shift_nxt  = {odd_parity(tx_data), tx_data};
          w_bitcnt_nxt = {CNT_W{1'b0}};
        end else begin
          w_shift_nxt  = r_shift;
        end
      end
      ST_INHIBIT: begin
        if (w_next == ST_REQ) w_drive_nxt = 1'b1;
        else                  w_drive_nxt = r_data_oe;
      end
      ST_WAIT_START, ST_SHIFT: begin
        if (w_clk_fall) begin
          w_drive_nxt  = (r_bitcnt == PAYLOAD_CNT) ? 1'b0 : ~r_shift[0];
          w_shift_nxt  = {1'b1, r_shift[PS2_PAYLOAD_BITS-1:1]};
          w_bitcnt_nxt = r_bitcnt + CNT_W'(1);
        end else begin
          w_drive_nxt  = r_data_oe;
        end
      end
      default: w_drive_nxt = r_data_oe;
    endcase
    w_release     = (w_next == ST_IDLE) || (w_next == ST_DONE) || (w_next == ST_ERROR);
    w_data_oe_nxt = w_release ? 1'b0 : w_drive_nxt;
    w_clk_oe_nxt  = (w_next == ST_INHIBIT) || (w_next == ST_REQ);
    w_busy_nxt    = !w_release;
    w_done_nxt    = (w_next == ST_DONE);
    w_error_nxt   = (w_next == ST_ERROR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= {PS2_PAYLOAD_BITS{1'b1}};
      r_bitcnt  <= {CNT_W{1'b0}};
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
    end else begin
      r_shift   <= w_shift_nxt;
      r_bitcnt  <= w_bitcnt_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_error   <= w_error_nxt;
      r_clk_oe  <= w_clk_oe_nxt;
      r_data_oe <= w_data_oe_nxt;
    end
  end

  assign tx_busy     = r_busy;
  assign tx_done     = r_done;
  assign tx_error    = r_error;
  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-collector keyboard model clocks frames out of
// the host and each received frame is compared with a byte-level reference.
module tb_ps2_host_tx;

  localparam int CLK_HZ      = 1_000_000;
  localparam int INHIBIT_CYC = 100;
  localparam int START_CYC   = 15000;
  localparam int HALF        = 43;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy, tx_done, tx_error;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low, dev_data_low;
  logic       clk_line, data_line;

  int vectors     = 0;
  int miscompares = 0;
  int n_done      = 0;
  int n_err       = 0;
  int n_both      = 0;

  assign clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign data_line = ~(ps2_data_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .CLK_FREQ_HZ (CLK_HZ),
    .INHIBIT_US  (100),
    .START_TO_US (15000),
    .FRAME_TO_US (2000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .tx_error    (tx_error),
    .ps2_clk_in  (clk_line),
    .ps2_data_in (data_line),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  always @(negedge clk) begin
    if (tx_done === 1'b1) n_done <= n_done + 1;
    if (tx_error === 1'b1) n_err <= n_err + 1;
    if (tx_done === 1'b1 && tx_error === 1'b1) n_both <= n_both + 1;
  end

  // What the device should read on rising edges 1..10: data LSB first, odd parity, stop.
  function automatic logic [9:0] exp_frame(input logic [7:0] b);
    int v;
    int ones;
    logic [9:0] f;
    v = int'(b);
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      f[i] = (((v >> i) % 2) == 1);
      ones += (v >> i) % 2;
    end
    f[8] = ((ones % 2) == 0);
    f[9] = 1'b1;
    return f;
  endfunction

  task automatic pulse_start(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  // Keyboard model: waits for request-to-send, then produces n_edges clock pulses.
  task automatic device_frame(input logic ack, input int n_edges, output logic [9:0] got,
                              output logic rts_ok, output int inh);
    int t;
    t      = 0;
    inh    = 0;
    got    = {10{1'bx}};
    while (clk_line !== 1'b0 && t < 50) begin @(negedge clk); t++; end
    while (clk_line === 1'b0 && inh < 4 * INHIBIT_CYC) begin @(negedge clk); inh++; end
    rts_ok = (clk_line === 1'b1) && (data_line === 1'b0);
    if (rts_ok) begin
      repeat (20) @(negedge clk);
      for (int e = 1; e <= n_edges; e++) begin
        if (e == 11 && ack) begin
          dev_data_low = 1'b1;
          repeat (10) @(negedge clk);
        end
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        if (e <= 10) got[e-1] = data_line;
        if (e < n_edges) repeat (HALF) @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_data_oe} !== 5'b00000) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b want 00000", {tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_data_oe});
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    vectors++;
    if ({tx_busy, tx_done, tx_error, clk_line, data_line} !== 5'b00011) begin
      miscompares++;
      $display("FAIL idle_after_reset: got %b want 00011", {tx_busy, tx_done, tx_error, clk_line, data_line});
    end
  endtask

  task automatic test_frame(input logic [7:0] b, input string name);
    logic [9:0] got;
    logic       rts_ok;
    int         inh, d0, e0, t;
    d0 = n_done;
    e0 = n_err;
    pulse_start(b);
    vectors++;
    if (tx_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL %s busy_on_start: got %b want 1", name, tx_busy);
    end
    device_frame(1'b1, 11, got, rts_ok, inh);
    vectors++;
    if (rts_ok !== 1'b1 || inh < INHIBIT_CYC) begin
      miscompares++;
      $display("FAIL %s request_to_send: rts %b inhibit %0d cycles, want rts 1 and >= %0d", name, rts_ok, inh, INHIBIT_CYC);
    end
    vectors++;
    if (got !== exp_frame(b)) begin
      miscompares++;
      $display("FAIL %s frame_bits: got %b want %b (byte %h)", name, got, exp_frame(b), b);
    end
    t = 0;
    while (n_done == d0 && t < 200) begin @(negedge clk); t++; end
    @(negedge clk);
    vectors++;
    if (n_done !== d0 + 1 || n_err !== e0) begin
      miscompares++;
      $display("FAIL %s done_pulse: done %0d err %0d want done %0d err %0d", name, n_done - d0, n_err - e0, 1, 0);
    end
    vectors++;
    if ({tx_busy, ps2_clk_oe, ps2_data_oe} !== 3'b000) begin
      miscompares++;
      $display("FAIL %s idle_after_done: busy/clk_oe/data_oe %b want 000", name, {tx_busy, ps2_clk_oe, ps2_data_oe});
    end
  endtask

  task automatic test_known_bytes();
    test_frame(8'hED, "byte_ED");
    test_frame(8'h01, "byte_01");
    test_frame(8'hFF, "byte_FF");
    test_frame(8'h00, "byte_00");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) test_frame(8'($urandom_range(0, 255)), "random");
  endtask

  task automatic test_busy_ignore();
    logic [9:0] got;
    logic       rts_ok;
    logic [7:0] a;
    int         inh, d0, t, busy_seen;
    a  = 8'($urandom_range(0, 255));
    d0 = n_done;
    pulse_start(a);
    fork
      device_frame(1'b1, 11, got, rts_ok, inh);
      begin
        repeat (400) @(negedge clk);
        tx_data  = ~a;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
      end
    join
    vectors++;
    if (got !== exp_frame(a)) begin
      miscompares++;
      $display("FAIL busy_ignore frame_bits: got %b want %b (byte %h)", got, exp_frame(a), a);
    end
    t = 0;
    while (tx_done !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    tx_data  = 8'h5A;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    busy_seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (tx_busy !== 1'b0 || clk_line !== 1'b1) busy_seen++;
    end
    vectors++;
    if (n_done !== d0 + 1 || busy_seen !== 0) begin
      miscompares++;
      $display("FAIL busy_ignore start_ignored: done %0d busy cycles %0d want done 1 busy cycles 0", n_done - d0, busy_seen);
    end
  endtask

  task automatic test_no_ack();
    logic [9:0] got;
    logic       rts_ok;
    logic [7:0] b;
    int         inh, d0, e0, t;
    b  = 8'($urandom_range(0, 255));
    d0 = n_done;
    e0 = n_err;
    pulse_start(b);
    device_frame(1'b0, 11, got, rts_ok, inh);
    vectors++;
    if (got !== exp_frame(b)) begin
      miscompares++;
      $display("FAIL no_ack frame_bits: got %b want %b", got, exp_frame(b));
    end
    t = 0;
    while (n_err == e0 && t < 200) begin @(negedge clk); t++; end
    repeat (20) @(negedge clk);
    vectors++;
    if (n_err !== e0 + 1 || n_done !== d0 || {tx_busy, ps2_clk_oe, ps2_data_oe} !== 3'b000) begin
      miscompares++;
      $display("FAIL no_ack error_pulse: err %0d done %0d busy/oe %b want err 1 done 0 busy/oe 000",
               n_err - e0, n_done - d0, {tx_busy, ps2_clk_oe, ps2_data_oe});
    end
  endtask

  task automatic test_start_timeout();
    int t, d0;
    d0 = n_done;
    pulse_start(8'hAA);
    t = 0;
    while (clk_line !== 1'b1 && t < 500) begin @(negedge clk); t++; end
    t = 0;
    while (tx_error !== 1'b1 && t < START_CYC + 100) begin @(negedge clk); t++; end
    vectors++;
    if (t < START_CYC - 1 || t > START_CYC + 1) begin
      miscompares++;
      $display("FAIL start_timeout latency: got %0d cycles want %0d", t, START_CYC);
    end
    vectors++;
    if ({ps2_clk_oe, ps2_data_oe, tx_busy, tx_done} !== 4'b0000) begin
      miscompares++;
      $display("FAIL start_timeout release: clk_oe/data_oe/busy/done %b want 0000", {ps2_clk_oe, ps2_data_oe, tx_busy, tx_done});
    end
    @(negedge clk);
    vectors++;
    if (tx_error !== 1'b0 || n_done !== d0) begin
      miscompares++;
      $display("FAIL start_timeout pulse_width: error %b extra done %0d want 0 and 0", tx_error, n_done - d0);
    end
  endtask

  task automatic test_reset_midframe();
    logic [9:0] got;
    logic       rts_ok;
    int         inh;
    pulse_start(8'hED);
    device_frame(1'b1, 5, got, rts_ok, inh);
    vectors++;
    if (ps2_data_oe !== 1'b1 || tx_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL midframe before_reset: data_oe %b busy %b want 1 1", ps2_data_oe, tx_busy);
    end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if ({ps2_clk_oe, ps2_data_oe, tx_busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL midframe async_release: clk_oe/data_oe/busy %b want 000", {ps2_clk_oe, ps2_data_oe, tx_busy});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    test_frame(8'hF4, "after_reset_F4");
  endtask

  initial begin
    rst_n        = 1'b0;
    tx_data      = 8'h00;
    tx_start     = 1'b0;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    test_reset();
    test_known_bytes();
    test_back_to_back();
    test_busy_ignore();
    test_no_ack();
    test_start_timeout();
    test_reset_midframe();
    vectors++;
    if (n_both !== 0) begin
      miscompares++;
      $display("FAIL done_error_exclusive: overlapping cycles %0d want 0", n_both);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
